// File: rtl/avalon_data_master.sv
// Bridge from the core's level-held data-memory requests to single Avalon-MM word
// transactions, with one-cycle completion pulse and a hung-slave timeout.
module avalon_data_master #(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        RRam,
    input  logic        WRam,
    input  logic [31:0] daddr,
    input  logic [31:0] ddata_w,
    output logic [31:0] ddata_r,
    output logic        done_ext,
    output logic        err,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        DONE    = 3'd4
    } state_e;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] ddata_r_q, ddata_r_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic        timeout;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = ^daddr[1:0];
    assign timeout         = (cnt_q == CNT_LAST);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ddata_r_q <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ddata_r_q <= ddata_r_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
        end
    end

    // A genuine completion in the last allowed cycle beats the timeout.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ddata_r_d = ddata_r_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        unique case (state_q)
            IDLE: begin
                if (RRam) begin
                    addr_d  = {daddr[31:2], 2'b00};
                    cnt_d   = '0;
                    state_d = RD_REQ;
                end else if (WRam) begin
                    addr_d  = {daddr[31:2], 2'b00};
                    wdata_d = ddata_w;
                    cnt_d   = '0;
                    state_d = WR_REQ;
                end
            end
            RD_REQ: begin
                cnt_d = cnt_q + 16'd1;
                if (!avm_waitrequest && avm_readdatavalid) begin
                    ddata_r_d = avm_readdata;
                    state_d   = DONE;
                end else if (timeout) begin
                    ddata_r_d = ERR_DATA;
                    err_d     = 1'b1;
                    state_d   = DONE;
                end else if (!avm_waitrequest) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                cnt_d = cnt_q + 16'd1;
                if (avm_readdatavalid) begin
                    ddata_r_d = avm_readdata;
                    state_d   = DONE;
                end else if (timeout) begin
                    ddata_r_d = ERR_DATA;
                    err_d     = 1'b1;
                    state_d   = DONE;
                end
            end
            WR_REQ: begin
                cnt_d = cnt_q + 16'd1;
                if (!avm_waitrequest) begin
                    state_d = DONE;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign avm_read       = (state_q == RD_REQ);
    assign avm_write      = (state_q == WR_REQ);
    assign done_ext       = (state_q == DONE);
    assign avm_address    = addr_q;
    assign avm_writedata  = wdata_q;
    assign avm_byteenable = 4'hF;
    assign ddata_r        = ddata_r_q;
    assign err            = err_q;

endmodule

// File: tb/tb_avalon_data_master.sv
// Self-checking bench for avalon_data_master: directed vector table, hand-written
// corner sequences and randomized transactions against a latency/data model.
module tb_avalon_data_master;

    localparam int          TCYC = 8;
    localparam logic [31:0] ERRV = 32'hDEADBEEF;

    logic        CLK;
    logic        RST_N;
    logic        RRam;
    logic        WRam;
    logic [31:0] daddr;
    logic [31:0] ddata_w;
    logic [31:0] ddata_r;
    logic        done_ext;
    logic        err;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;

    int passCount  = 0;
    int checkCount = 0;

    // Slave model state and per-transaction observations
    int          sWait, sResp, sStrobeCyc, sCountdown;
    logic [31:0] sRdata, expAddr, expWdata;
    int          rdStrobes, wrStrobes, addrErrs;

    avalon_data_master #(.TIMEOUT_CYC(TCYC), .ERR_DATA(ERRV)) dut (
        .CLK               (CLK),
        .RST_N             (RST_N),
        .RRam              (RRam),
        .WRam              (WRam),
        .daddr             (daddr),
        .ddata_w           (ddata_w),
        .ddata_r           (ddata_r),
        .done_ext          (done_ext),
        .err               (err),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_byteenable    (avm_byteenable),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Slave behaviour for the current cycle; stray readdatavalid pulses are
    // thrown in wherever the master must ignore them.
    task automatic driveSlave();
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata      = $urandom;
        if (avm_read || avm_write) begin
            sStrobeCyc++;
            if (avm_read) rdStrobes++;
            else wrStrobes++;
            if (avm_address !== expAddr) addrErrs++;
            if (avm_write && avm_writedata !== expWdata) addrErrs++;
            if (sStrobeCyc <= sWait) begin
                avm_waitrequest   = 1'b1;
                avm_readdatavalid = 1'b1;
            end else if (avm_read) begin
                if (sResp == 0) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = sRdata;
                end else begin
                    sCountdown = sResp;
                end
            end else begin
                avm_readdatavalid = 1'b1;
            end
        end else if (sCountdown > 0) begin
            sCountdown--;
            if (sCountdown == 0) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = sRdata;
            end
        end else begin
            avm_readdatavalid = 1'b1;
        end
    endtask

    task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdata,
                                 input int waitCyc, input int respLat,
                                 output int latency, output int firstStrobe,
                                 output logic [31:0] dataOut, output logic errOut);
        sWait = waitCyc; sResp = respLat; sRdata = rdata;
        sStrobeCyc = 0; sCountdown = 0;
        rdStrobes = 0; wrStrobes = 0; addrErrs = 0;
        expAddr  = {addr[31:2], 2'b00};
        expWdata = wdata;
        RRam = rd; WRam = wr; daddr = addr; ddata_w = wdata;
        driveSlave();
        latency = -1; firstStrobe = -1; dataOut = 'x; errOut = 1'bx;
        for (int cyc = 1; cyc <= 40 && latency < 0; cyc++) begin
            @(posedge CLK); #1;
            driveSlave();
            if ((avm_read || avm_write) && firstStrobe < 0) firstStrobe = cyc;
            @(negedge CLK);
            if (done_ext) begin
                latency = cyc;
                dataOut = ddata_r;
                errOut  = err;
                if (rd) RRam = 1'b0;
                else WRam = 1'b0;
            end
        end
        if (latency < 0) begin
            RRam = 1'b0;
            WRam = 1'b0;
        end
        @(posedge CLK); #1;
        driveSlave();
    endtask

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waitCyc;
        int          respLat;
        logic [31:0] expData;
        int          expLat;
        int          expRd;
        int          expWr;
    } vec_t;

    vec_t        vecs[6];
    int          lat, first, waitCyc, respLat, normal, expLat;
    logic [31:0] dOut, addr, wdata, rdata, lastData;
    logic        eOut, errModel;
    bit          rd, timedOut;

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'h0000_0107, 32'h0,         32'h1234_5678, 0, 1, 32'h1234_5678, 3, 1, 0};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_0040, 32'hA5A5_A5A5, 32'h0,         4, 0, 32'h1234_5678, 6, 0, 5};
        vecs[2] = '{1'b1, 1'b0, 32'h2000_0012, 32'h0,         32'hCAFE_F00D, 0, 0, 32'hCAFE_F00D, 2, 1, 0};
        vecs[3] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0,         32'h0BAD_C0DE, 2, 2, 32'h0BAD_C0DE, 6, 3, 0};
        vecs[4] = '{1'b0, 1'b1, 32'h8000_0003, 32'h1357_9BDF, 32'h0,         0, 0, 32'h0BAD_C0DE, 2, 0, 1};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_0700, 32'h0,         32'h0F0F_0F0F, 3, 4, 32'h0F0F_0F0F, 9, 4, 0};

        RST_N = 1'b0; RRam = 1'b0; WRam = 1'b0; daddr = '0; ddata_w = '0;
        avm_waitrequest = 1'b0; avm_readdata = '0; avm_readdatavalid = 1'b0;
        sWait = 0; sResp = 0; sStrobeCyc = 0; sCountdown = 0; sRdata = '0;
        expAddr = '0; expWdata = '0; rdStrobes = 0; wrStrobes = 0; addrErrs = 0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checkOutput("reset ddata_r", ddata_r, 32'h0);
        checkOutput("reset done_ext", {31'h0, done_ext}, 32'h0);
        checkOutput("reset err", {31'h0, err}, 32'h0);
        checkOutput("reset avm_read", {31'h0, avm_read}, 32'h0);
        checkOutput("reset avm_write", {31'h0, avm_write}, 32'h0);
        checkOutput("reset avm_address", avm_address, 32'h0);
        checkOutput("reset avm_writedata", avm_writedata, 32'h0);
        checkOutput("reset byteenable", {28'h0, avm_byteenable}, 32'hF);
        RST_N = 1'b1;
        @(posedge CLK); #1;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdata,
                          vecs[i].waitCyc, vecs[i].respLat, lat, first, dOut, eOut);
            checkOutput($sformatf("vec%0d latency", i), lat, vecs[i].expLat);
            checkOutput($sformatf("vec%0d strobe start", i), first, 1);
            checkOutput($sformatf("vec%0d ddata_r", i), dOut, vecs[i].expData);
            checkOutput($sformatf("vec%0d err", i), {31'h0, eOut}, 32'h0);
            checkOutput($sformatf("vec%0d read strobes", i), rdStrobes, vecs[i].expRd);
            checkOutput($sformatf("vec%0d write strobes", i), wrStrobes, vecs[i].expWr);
            checkOutput($sformatf("vec%0d addr/data stability", i), addrErrs, 0);
            checkOutput($sformatf("vec%0d done pulse width", i), {31'h0, done_ext}, 32'h0);
        end

        // Simultaneous read and write: read first, write issued from IDLE afterwards
        applyStimulus(1'b1, 1'b1, 32'h0000_0300, 32'h1111_2222, 32'h5555_6666, 1, 1, lat, first, dOut, eOut);
        checkOutput("simul read latency", lat, 4);
        checkOutput("simul read data", dOut, 32'h5555_6666);
        checkOutput("simul read strobes", rdStrobes, 2);
        checkOutput("simul no early write", wrStrobes, 0);
        applyStimulus(1'b0, 1'b1, 32'h0000_0300, 32'h1111_2222, 32'h0, 0, 0, lat, first, dOut, eOut);
        checkOutput("simul write latency", lat, 2);
        checkOutput("simul write strobes", wrStrobes, 1);
        checkOutput("simul no second read", rdStrobes, 0);
        checkOutput("simul write data held", dOut, 32'h5555_6666);
        checkOutput("simul write addr/data", addrErrs, 0);

        // Read timeout: slave accepts but never answers
        applyStimulus(1'b1, 1'b0, 32'h0000_0500, 32'h0, 32'h7777_7777, 0, 100, lat, first, dOut, eOut);
        checkOutput("timeout done after strobe", lat - first, TCYC);
        checkOutput("timeout ddata_r", dOut, ERRV);
        checkOutput("timeout err", {31'h0, eOut}, 32'h1);
        applyStimulus(1'b1, 1'b0, 32'h0000_0504, 32'h0, 32'h2468_1357, 0, 1, lat, first, dOut, eOut);
        checkOutput("post-timeout read data", dOut, 32'h2468_1357);
        checkOutput("post-timeout latency", lat, 3);
        checkOutput("err sticky", {31'h0, eOut}, 32'h1);

        // Reset during RD_WAIT followed by a late response
        sWait = 0; sResp = 3; sRdata = 32'hFFFF_0000; sStrobeCyc = 0; sCountdown = 0;
        expAddr = 32'h0000_0600;
        RRam = 1'b1; daddr = 32'h0000_0600;
        driveSlave();
        @(posedge CLK); #1; driveSlave();
        @(posedge CLK); #1; driveSlave();
        RST_N = 1'b0; RRam = 1'b0;
        #1;
        checkOutput("midreset ddata_r", ddata_r, 32'h0);
        checkOutput("midreset err", {31'h0, err}, 32'h0);
        checkOutput("midreset done_ext", {31'h0, done_ext}, 32'h0);
        checkOutput("midreset avm_read", {31'h0, avm_read}, 32'h0);
        checkOutput("midreset avm_write", {31'h0, avm_write}, 32'h0);
        checkOutput("midreset avm_address", avm_address, 32'h0);
        checkOutput("midreset avm_writedata", avm_writedata, 32'h0);
        @(negedge CLK);
        RST_N = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge CLK); #1; driveSlave();
            @(negedge CLK);
            checkOutput($sformatf("late rdv ddata_r c%0d", c), ddata_r, 32'h0);
            checkOutput($sformatf("late rdv done_ext c%0d", c), {31'h0, done_ext}, 32'h0);
        end
        @(posedge CLK); #1;

        // Randomized transactions against the latency/data model
        lastData = 32'h0;
        errModel = 1'b0;
        for (int i = 0; i < 40; i++) begin
            rd      = 1'($urandom_range(0, 1));
            waitCyc = ($urandom_range(0, 7) == 0) ? 10 : int'($urandom_range(0, 3));
            respLat = ($urandom_range(0, 7) == 0) ? 12 : int'($urandom_range(0, 3));
            addr    = $urandom;
            wdata   = $urandom;
            rdata   = $urandom;
            normal   = rd ? waitCyc + respLat + 2 : waitCyc + 2;
            timedOut = (normal > TCYC + 1);
            expLat   = timedOut ? TCYC + 1 : normal;
            if (rd) lastData = timedOut ? ERRV : rdata;
            if (timedOut) errModel = 1'b1;
            applyStimulus(rd, !rd, addr, wdata, rdata, waitCyc, respLat, lat, first, dOut, eOut);
            checkOutput($sformatf("rand%0d latency", i), lat, expLat);
            checkOutput($sformatf("rand%0d ddata_r", i), dOut, lastData);
            checkOutput($sformatf("rand%0d err", i), {31'h0, eOut}, {31'h0, errModel});
            checkOutput($sformatf("rand%0d addr/data stability", i), addrErrs, 0);
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
